// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU: one outstanding load/store at a time,
// word-addressed internal RAM, response after a fixed programmable latency.
module lsu_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         cnt;
  logic               wen_q;
  logic               in_range_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wmask_q;
  logic [31:0]        rd_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               enter_resp;
  logic               in_range;
  logic [31:0]        offset;
  logic               unused_bits;

  assign accept     = req_valid && req_ready;
  // WAIT is left once the counter has reached zero, so WAIT lasts LATENCY+1
  // cycles and resp_valid rises LATENCY+1 edges after the accept edge.
  assign enter_resp = (state == WAIT) && (cnt == 4'd0);
  assign in_range   = (req_addr >= ADDR_BASE) && ({1'b0, req_addr} < ADDR_LIMIT);
  assign offset     = req_addr - ADDR_BASE;
  assign unused_bits = ^{req_wmask[7:4], offset[31:IDX_W+2], offset[1:0]};

  // State register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_valid && resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESP);
    resp_err   = resp_valid && !in_range_q;
    resp_rdata = (resp_valid && in_range_q && !wen_q) ? rd_q : '0;
  end

  // Request capture and latency countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      wen_q      <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (accept) begin
      cnt        <= 4'(LATENCY);
      wen_q      <= req_wen;
      in_range_q <= in_range;
      idx_q      <= offset[IDX_W+1:2];
      wdata_q    <= req_wdata;
      wmask_q    <= req_wmask[3:0];
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // RAM access on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clock) begin
    if (enter_resp && in_range_q) begin
      if (wen_q) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (wmask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end else begin
        rd_q <= mem[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed self-checking bench for lsu_mem_responder (LATENCY=2 and LATENCY=0).
module tb_lsu_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_wen;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [7:0]  z_req_wmask;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;

  int checks = 0;
  int failures = 0;
  int cyc_count = 0;

  lsu_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  lsu_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wen(z_req_wen),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc_count <= cyc_count + 1;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full request/response on the LATENCY=2 instance with resp_ready high.
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] mask,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    resp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin cyc(); n++; end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    cyc();
    check({tag, "_vld_clr"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata_clr"}, resp_rdata, 32'd0);
    check({tag, "_rdy_next"}, 32'(req_ready), 32'd1);
  endtask

  logic        v_wen   [6];
  logic [31:0] v_addr  [6];
  logic [31:0] v_wdata [6];
  logic [7:0]  v_mask  [6];
  logic [31:0] v_exp   [6];
  int          acc     [6];

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wmask = '0;
    z_resp_ready = 1'b1;

    #2;
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_vld", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_z_rdy", 32'(z_req_ready), 32'd0);
    cyc(); cyc();
    check("rst_rdy_held", 32'(req_ready), 32'd0);
    reset = 1'b0;
    cyc();
    check("post_rst_rdy", 32'(req_ready), 32'd1);

    // Basic store / load
    txn("st_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0);
    txn("ld_full", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0);

    // Byte lanes, upper mask bits ignored
    txn("st_mask", 1'b1, 32'h8000_0010, 32'h1122_3344, 8'h05, 32'h0, 1'b0);
    txn("ld_mask", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDE22_BE44, 1'b0);
    txn("st_mask_hi", 1'b1, 32'h8000_0010, 32'h1122_3344, 8'hF5, 32'h0, 1'b0);
    txn("ld_mask_hi", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDE22_BE44, 1'b0);
    txn("st_nomask", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 32'h0, 1'b0);
    txn("ld_nomask", 1'b0, 32'h8000_0013, 32'h0, 8'h00, 32'hDE22_BE44, 1'b0);

    // Backpressure: hold resp_ready low, present a store that must be ignored
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 8'h00;
    resp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin cyc(); n++; end
    check("bp_lat", 32'(n), 32'd3);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wmask = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDE22_BE44);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_rdy", 32'(req_ready), 32'd0);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    check("bp_vld_clr", 32'(resp_valid), 32'd0);
    check("bp_rdy_after", 32'(req_ready), 32'd1);
    txn("bp_readback", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDE22_BE44, 1'b0);

    // Range boundaries
    txn("st_w0", 1'b1, 32'h8000_0000, 32'h0102_0304, 8'h0F, 32'h0, 1'b0);
    txn("st_top", 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b0);
    txn("ld_top", 1'b0, 32'h8000_0FFC, 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0);
    txn("ld_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 32'h0, 1'b1);
    txn("ld_above", 1'b0, 32'h8000_1000, 32'h0, 8'h00, 32'h0, 1'b1);
    txn("st_above", 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 32'h0, 1'b1);
    txn("ld_w0", 1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0102_0304, 1'b0);

    // Reset during WAIT of a store drops it without writing
    txn("st_pre", 1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 8'h0F, 32'h0, 1'b0);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678; req_wmask = 8'h0F;
    cyc();
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rw_vld", 32'(resp_valid), 32'd0);
    check("rw_rdy", 32'(req_ready), 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    txn("rw_readback", 1'b0, 32'h8000_0020, 32'h0, 8'h00, 32'hA5A5_A5A5, 1'b0);

    // Reset during RESP clears the response without a clock edge
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 8'h00;
    resp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin cyc(); n++; end
    check("rr_vld_set", 32'(resp_valid), 32'd1);
    check("rr_rdata_set", resp_rdata, 32'hDE22_BE44);
    #2 reset = 1'b1;
    #1;
    check("rr_vld", 32'(resp_valid), 32'd0);
    check("rr_rdata", resp_rdata, 32'd0);
    check("rr_err", 32'(resp_err), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    txn("rr_ld10", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDE22_BE44, 1'b0);
    txn("rr_ld0", 1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0102_0304, 1'b0);
    txn("rr_ldtop", 1'b0, 32'h8000_0FFC, 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0);

    // LATENCY=0 instance: back-to-back stream with resp_ready tied high
    v_wen   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v_addr  = '{32'h8000_0100, 32'h8000_0104, 32'h8000_0100, 32'h8000_0104, 32'h8000_0104, 32'h8000_0104};
    v_wdata = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    v_mask  = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h03, 8'h00};
    v_exp   = '{32'h0, 32'h0, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h0, 32'h1357_FFFF};
    for (int k = 0; k < 6; k++) begin
      z_req_wen = v_wen[k]; z_req_addr = v_addr[k]; z_req_wdata = v_wdata[k]; z_req_wmask = v_mask[k];
      z_req_valid = 1'b1;
      n = 0;
      while (!z_req_ready && n < 10) begin cyc(); n++; end
      acc[k] = cyc_count;
      if (k > 0) check("z_gap", 32'(acc[k] - acc[k-1]), 32'd3);
      cyc();
      if (k == 5) z_req_valid = 1'b0;
      n = 0;
      while (!z_resp_valid && n < 10) begin cyc(); n++; end
      check("z_lat", 32'(n), 32'd1);
      check("z_rdata", z_resp_rdata, v_exp[k]);
      check("z_err", 32'(z_resp_err), 32'd0);
      n = 0;
      while (!z_req_ready && n < 10) begin cyc(); n++; end
      check("z_rdy_wait", 32'(n), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
